// File: rtl/ysyx_25030093_ifu_pf.sv
// ysyx_25030093_ifu_pf -- prefetching instruction fetch unit.
//
// Issues sequential instruction reads on an AR/R read channel. Several reads
// may be in flight at once. Returned instructions are buffered in a
// DEPTH-entry FIFO that feeds decode over a valid/ready port. A redirect
// restarts fetch at a new PC and discards every stale response.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   redirect_valid/_pc       one-cycle restart request and its target PC
//                            (bits [1:0] of the PC are ignored)
//   out_valid/ready/inst/pc  decode handoff of the FIFO head
//   out_err                  head fetch returned an error response
//   IFU_SRAM_araddr/arvalid, SRAM_IFU_arready    read address channel
//   SRAM_IFU_rvalid/rdata/rresp, IFU_SRAM_rready read data channel
//
// Build option: define YSYX_IFU_PF_RRESP_EN to add SRAM_IFU_rresp and out_err.
// With that option, a non-zero rresp marks the buffered entry as faulting.
// Without it, both ports are absent and no entry carries an error.
module ysyx_25030093_ifu_pf #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
`ifdef YSYX_IFU_PF_RRESP_EN
  output logic            out_err,
`endif
  output logic [XLEN-1:0] IFU_SRAM_araddr,
  output logic            IFU_SRAM_arvalid,
  input  logic            SRAM_IFU_arready,
  input  logic            SRAM_IFU_rvalid,
  output logic            IFU_SRAM_rready,
`ifdef YSYX_IFU_PF_RRESP_EN
  input  logic [1:0]      SRAM_IFU_rresp,
`endif
  input  logic [ILEN-1:0] SRAM_IFU_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] araddr_q, araddr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic            rready_q;

  logic [ILEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [CW:0]     used_c;
  logic [XLEN-1:0] redir_pc_c;
  logic            launch, r_fire, push, pop;

  // rready_q also gates the first launch, so fetch starts one cycle after
  // reset is released, together with rready.
  assign used_c     = {1'b0, cnt_q} + {1'b0, outst_q};
  assign launch     = (state_q == AR_IDLE) && rready_q && !redirect_valid &&
                      (used_c < (CW+1)'(DEPTH));
  assign r_fire     = SRAM_IFU_rvalid && rready_q;
  // A response is only buffered if it belongs to the current stream. A
  // response that arrives in the same cycle as a redirect is stale.
  assign push       = r_fire && (drop_q == '0) && !redirect_valid;
  assign pop        = out_valid && out_ready;
  assign redir_pc_c = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(launch) - CW'(r_fire);
    drop_d     = drop_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;

    case (state_q)
      AR_IDLE: if (launch) begin
        state_d    = AR_WAIT;
        araddr_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      default: if (SRAM_IFU_arready) state_d = AR_IDLE;
    endcase

    if (r_fire && drop_q != '0) drop_d = drop_q - CW'(1);
    if (push) resp_pc_d = resp_pc_q + XLEN'(4);

    if (redirect_valid) begin
      // Everything still in flight is stale. This includes a held AR and
      // any response that arrives in this same cycle.
      fetch_pc_d = redir_pc_c;
      resp_pc_d  = redir_pc_c;
      drop_d     = outst_d;
      cnt_d      = '0;
      rptr_d     = wptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= AR_IDLE;
      araddr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      rready_q   <= 1'b1;
    end
  end

  // FIFO storage needs no reset: entries are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wptr_q] <= SRAM_IFU_rdata;
      pc_mem[wptr_q]   <= resp_pc_q;
    end
  end

`ifdef YSYX_IFU_PF_RRESP_EN
  logic err_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) err_mem[wptr_q] <= (SRAM_IFU_rresp != 2'b00);
  end

  assign out_err = out_valid && err_mem[rptr_q];
`endif

  assign out_valid        = (cnt_q != '0);
  assign out_inst         = out_valid ? inst_mem[rptr_q] : '0;
  assign out_pc           = out_valid ? pc_mem[rptr_q]   : '0;
  assign IFU_SRAM_araddr  = araddr_q;
  assign IFU_SRAM_arvalid = (state_q == AR_WAIT);
  assign IFU_SRAM_rready  = rready_q;

endmodule

// File: tb/tb_ysyx_25030093_ifu_pf.sv
// Self-checking bench for ysyx_25030093_ifu_pf.
// An in-order memory model answers each accepted AR request one or more
// cycles later with rdata = addr ^ A5A5_A5A5. Each live response is pushed to
// a scoreboard when the bench drives it. Each decode pop is checked against
// the scoreboard.
module tb_ysyx_25030093_ifu_pf;
  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc;
  logic [31:0] araddr;
  logic        arvalid, rready;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
`ifdef YSYX_IFU_PF_RRESP_EN
  logic        out_err;
  logic [1:0]  rresp = 2'b00;
`endif

  always #5 clk = ~clk;

  ysyx_25030093_ifu_pf dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
`ifdef YSYX_IFU_PF_RRESP_EN
    .out_err(out_err),
`endif
    .IFU_SRAM_araddr(araddr), .IFU_SRAM_arvalid(arvalid),
    .SRAM_IFU_arready(arready), .SRAM_IFU_rvalid(rvalid),
    .IFU_SRAM_rready(rready),
`ifdef YSYX_IFU_PF_RRESP_EN
    .SRAM_IFU_rresp(rresp),
`endif
    .SRAM_IFU_rdata(rdata)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pend[$];

  // stimulus knobs, applied at the next step
  logic        k_rst = 1'b0, k_arrdy = 1'b0, k_ordy = 1'b0, k_ren = 1'b0, k_redir = 1'b0;
  logic [31:0] k_rpc = '0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  // bench-side model state
  logic [31:0] tb_next_ar = RPC;
  int          tb_drop = 0;
  logic        stale_hold = 1'b0, prev_ar_hold = 1'b0, gap_en = 1'b0;
  int          hs_cnt = 0, pop_cnt = 0, err_pops = 0, cyc = 0, last_pop = 0;
  logic [31:0] first_pop_pc = '0;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Called at a negedge, while DUT outputs are stable. It drives the inputs for
  // the coming posedge, then accounts for the handshakes that edge will do.
  task automatic step();
    exp_t        e;
    logic [31:0] a;
    if (prev_ar_hold && k_rst) chk("ar_held_valid", arvalid, 1);
    rst            = k_rst;
    arready        = k_arrdy;
    out_ready      = k_ordy;
    redirect_valid = k_redir;
    redirect_pc    = k_rpc;
    if (k_rst && k_ren && pend.size() > 0) begin
      rvalid = 1'b1;
      rdata  = pend[0] ^ MAGIC;
`ifdef YSYX_IFU_PF_RRESP_EN
      rresp  = (pend[0] == err_addr) ? 2'b10 : 2'b00;
`endif
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    if (!k_rst) begin
      pend.delete(); sb.delete();
      tb_next_ar = RPC; tb_drop = 0; stale_hold = 1'b0; prev_ar_hold = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_inst", out_inst, e.inst);
`ifdef YSYX_IFU_PF_RRESP_EN
          chk("out_err", out_err, e.err);
          if (out_err) err_pops++;
`endif
        end
        if (gap_en && pop_cnt > 0) chk("gap_le2", (cyc - last_pop) <= 2, 1);
        if (pop_cnt == 0) first_pop_pc = out_pc;
        last_pop = cyc;
        pop_cnt++;
      end
      if (rvalid) begin
        a = pend.pop_front();
        if (tb_drop > 0) tb_drop--;
        else if (!k_redir) begin
          e.pc = a; e.inst = a ^ MAGIC; e.err = (a == err_addr);
          sb.push_back(e);
        end
      end
      if (arvalid && arready) begin
        if (stale_hold) stale_hold = 1'b0;
        else begin
          chk("araddr", araddr, tb_next_ar);
          tb_next_ar += 4;
        end
        pend.push_back(araddr);
        hs_cnt++;
      end
      if (k_redir) begin
        sb.delete();
        tb_next_ar = {k_rpc[31:2], 2'b00};
        stale_hold = arvalid && !arready;
        tb_drop    = pend.size() + (stale_hold ? 1 : 0);
      end
      prev_ar_hold = arvalid && !arready;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_pops(input string tag, input int n);
    int b = 0;
    while (pop_cnt < n && b < 300) begin step(); b++; end
    chk({tag, "_pops"}, pop_cnt >= n, 1);
  endtask

  task automatic wait_hs(input string tag, input int n);
    int b = 0;
    while (hs_cnt < n && b < 300) begin step(); b++; end
    chk({tag, "_hs"}, hs_cnt >= n, 1);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_inst"}, out_inst, 0);
    chk({tag, "_out_pc"}, out_pc, 0);
`ifdef YSYX_IFU_PF_RRESP_EN
    chk({tag, "_out_err"}, out_err, 0);
`endif
  endtask

  task automatic do_reset();
    k_rst = 1'b0; k_redir = 1'b0;
    step(); step();
    k_rst = 1'b1; hs_cnt = 0; pop_cnt = 0;
  endtask

  initial begin
    int b;
    @(negedge clk);
    repeat (3) step();
    reset_chk("rst0");

    // sequential fetch, zero-wait memory, decode always ready
    k_rst = 1'b1; k_arrdy = 1'b1; k_ren = 1'b1; k_ordy = 1'b1; gap_en = 1'b1;
    step(); step();
    chk("rready_up", rready, 1);
    wait_pops("seq", 8);
    chk("seq_first_pc", first_pop_pc, RPC);
    gap_en = 1'b0;

    // credit limit: decode stalled, only DEPTH requests may go out
    do_reset();
    k_ordy = 1'b0;
    repeat (30) step();
    chk("credit_hs", hs_cnt, 4);
    chk("credit_arvalid", arvalid, 0);
    chk("credit_valid", out_valid, 1);
    k_ordy = 1'b1; pop_cnt = 0;
    wait_pops("drain", 6);

    // redirect with two outstanding plus one held AR
    do_reset();
    k_ren = 1'b0;
    wait_hs("redir", 2);
    k_arrdy = 1'b0;
    repeat (3) step();
    chk("redir_held", arvalid, 1);
    k_redir = 1'b1; k_rpc = 32'h8000_1002;
    step();
    k_redir = 1'b0; k_arrdy = 1'b1; k_ren = 1'b1; pop_cnt = 0;
    wait_pops("redir", 3);
    chk("redir_first_pc", first_pop_pc, 32'h8000_1000);

    // redirect coinciding with a response and a decode pop
    do_reset();
    k_ordy = 1'b0;
    b = 0;
    while (!(out_valid && pend.size() > 0) && b < 100) begin step(); b++; end
    chk("coinc_setup", out_valid && pend.size() > 0, 1);
    k_ordy = 1'b1; k_redir = 1'b1; k_rpc = 32'h8000_2000; pop_cnt = 0;
    step();
    k_redir = 1'b0;
    chk("coinc_popped", pop_cnt, 1);
    chk("coinc_empty", out_valid, 0);
    pop_cnt = 0;
    wait_pops("coinc", 3);
    chk("coinc_first_pc", first_pop_pc, 32'h8000_2000);

`ifdef YSYX_IFU_PF_RRESP_EN
    // error response on the second fetch
    do_reset();
    err_addr = 32'h8000_0004; err_pops = 0;
    wait_pops("err", 4);
    chk("err_count", err_pops, 1);
    err_addr = 32'hFFFF_FFFF;
`endif

    // reset while requests are in flight
    do_reset();
    k_ren = 1'b0;
    wait_hs("midrst", 2);
    k_rst = 1'b0;
    step();
    reset_chk("midrst");
    k_rst = 1'b1; k_ren = 1'b1; hs_cnt = 0; pop_cnt = 0;
    wait_pops("midrst", 2);
    chk("midrst_first_pc", first_pop_pc, RPC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
